vec_regfile_kbank: RTL
======================

// Module: vec_regfile_kbank
// PURPOSE
//  Parametrised vector register file for the filter GPU datapath: LANES x LANE_W lanes per register,
//  two combinational read ports, one per-lane-masked write port. The top NKREG addresses are a
//  read-only kernel window served from one of NBANKS kernel banks chosen by `kernel`. Banks are
//  reloaded at run time through a valid/ready stream with a load FSM and shadow buffer.
// PARAMETERS
//  LANES   3   lanes per vector register
//  LANE_W  18  bits per lane, two's complement
//  NREGS   16  total addresses, general + kernel window; AW = $clog2(NREGS)
//  NKREG   4   kernel registers per bank, mapped to addresses NREGS-NKREG..NREGS-1
//  NBANKS  4   kernel banks; KB = $clog2(NBANKS)
// PORTS
//  clk       in   1              clock, all state updates on posedge
//  reset     in   1              synchronous, active-low (asserted when 0)
//  kernel    in   KB             kernel bank shown in the kernel window
//  we3       in   1              write enable
//  ra1,ra2   in   AW             read addresses
//  ra3       in   AW             write address
//  wd3       in   LANES*LANE_W   write data, lane 0 in LSBs
//  wmask     in   LANES          per-lane write enable
//  rd1,rd2   out  LANES*LANE_W   read data
//  wr_err    out  1              pulse: write aimed at the kernel window
//  kl_valid  in   1              kernel-load beat valid
//  kl_ready  out  1              kernel-load beat accepted when valid&ready
//  kl_bank   in   KB             target bank, sampled on the first beat only
//  kl_data   in   LANE_W         one lane value per beat
//  kl_done   out  1              one-cycle pulse after a bank commit
//  kbusy     out  1              high while FSM is in LOAD or COMMIT
// BEHAVIOUR
//  - Reset (reset==0 at posedge): general regs = 0; every lane of every kernel bank = +1;
//    FSM = IDLE; beat counter = 0; wr_err = 0; kl_done = 0. Any load in progress is discarded.
//  - Reads: combinational. addr < NREGS-NKREG returns the general reg. Otherwise returns
//    bank[kernel][addr-(NREGS-NKREG)].
//  - Write: on posedge, if we3 and ra3 < NREGS-NKREG, lanes with wmask[i]=1 take wd3 lane i.
//    If we3 and ra3 is in the kernel window: no state change, and wr_err=1 the next cycle.
//    wmask=0 with we3=1 writes nothing and raises no error.
//  - Load FSM:
//    IDLE: kl_ready=1. First accepted beat latches kl_bank, stores the beat at shadow
//      index 0, and moves to LOAD.
//    LOAD: kl_ready=1. Beat n goes to shadow index n; order is reg0 lane0..lane(LANES-1),
//      then reg1, and so on. Beat count is NKREG*LANES total; after the last beat, go to COMMIT.
//    COMMIT (1 cycle): kl_ready=0. Shadow is copied into the latched bank. kl_done=1 the
//      following cycle. Return to IDLE.
//    Total latency: last beat accepted at cycle t -> bank updated at t+1 -> reads show new
//      values from t+2 if kernel==bank; kl_done high during t+2.
//  - Live banks never change before COMMIT; reads of the target bank during LOAD return old values.
//  - kl_valid low mid-load stalls the counter; there is no timeout.
//  - Changing `kernel` mid-load is legal and only switches which bank is read.
//  - Register writes and loads are independent and may occur in the same cycle.
//  - Reset mid-load: shadow and counter are cleared. Banks return to the reset pattern, including
//    any bank committed earlier.
// CONFIGURATION
//  RF_WRITE_BYPASS_EN defined: if we3=1 and ra3==raX is a general address, rdX lanes with
//    wmask[i]=1 return wd3 lane i in the same cycle (write-through). Other lanes return stored data.
//  Not defined: reads return the stored value until the posedge; no forwarding logic.
// TESTING
//  1. Reset low for 2 cycles, then read ra1=0, ra2=15 with kernel=0 -> rd1=0; rd2 = {1,1,1}.
//  2. we3=1, ra3=5, wd3={7,-3,9}, wmask=3'b101, then read ra1=5 -> {7,0,9}.
//  3. we3=1, ra3=13 -> next cycle wr_err=1 for 1 cycle, and ra1=13 still reads the bank value.
//  4. Stream 12 beats of values 1..12 to kl_bank=2 with kernel=2. After the last beat:
//     kl_ready=0 for 1 cycle; kl_done pulses 2 cycles later; ra1=12 reads {1,2,3}, ra1=15 reads {10,11,12}.
//  5. Stream 6 beats to kl_bank=1, then drop reset -> kbusy=0, and bank 1 reads all +1 after release.
//  6. Same-cycle we3/ra1 to address 3 with wd3={4,4,4}, wmask=3'b111 -> rd1={4,4,4} with
//     RF_WRITE_BYPASS_EN, old value without it.

Source files
------------

// File: rtl/vec_regfile_kbank.sv
// -----------------------------------------------------------------------------
// vec_regfile_kbank
//   Vector register file for the filter GPU datapath. Each register holds
//   LANES lanes of LANE_W bits. Two combinational read ports and one write
//   port with a per-lane mask. The top NKREG addresses form a read-only kernel
//   window. That window shows one of NBANKS kernel banks, selected by `kernel`.
//   Kernel banks are reloaded through a valid/ready beat stream. Beats collect
//   in a shadow buffer and are committed to the live bank in a single cycle.
//
//   Optional feature macro: RF_WRITE_BYPASS_EN
//     defined   : a write to a general register is forwarded, lane by lane
//                 (masked lanes only), to a read port that addresses the same
//                 register in the same cycle.
//     undefined : reads return the stored value until the clock edge.
//
//   Handshake: a kernel-load beat transfers on a rising clk edge where
//   kl_valid && kl_ready. kl_ready does not depend on kl_valid. While kl_valid
//   is low the load simply waits; it has no timeout.
// -----------------------------------------------------------------------------
module vec_regfile_kbank #(
    parameter int LANES  = 3,
    parameter int LANE_W = 18,
    parameter int NREGS  = 16,
    parameter int NKREG  = 4,
    parameter int NBANKS = 4,
    localparam int AW    = $clog2(NREGS),
    localparam int KB    = $clog2(NBANKS),
    localparam int VW    = LANES * LANE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [KB-1:0]     kernel,
    input  logic              we3,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    input  logic [AW-1:0]     ra3,
    input  logic [VW-1:0]     wd3,
    input  logic [LANES-1:0]  wmask,
    output logic [VW-1:0]     rd1,
    output logic [VW-1:0]     rd2,
    output logic              wr_err,
    input  logic              kl_valid,
    output logic              kl_ready,
    input  logic [KB-1:0]     kl_bank,
    input  logic [LANE_W-1:0] kl_data,
    output logic              kl_done,
    output logic              kbusy,
    output logic [1:0]        o_dbg_state
);

    // Number of general (writable) registers sitting below the kernel window.
    localparam int NGEN   = NREGS - NKREG;
    // Beats needed to fill one kernel bank: every lane of every kernel register.
    localparam int NBEATS = NKREG * LANES;
    localparam int CW     = $clog2(NBEATS + 1);
    localparam int SIW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int GIW    = (NGEN > 1) ? $clog2(NGEN) : 1;
    localparam int KIW    = (NKREG > 1) ? $clog2(NKREG) : 1;

    // Kernel banks come out of reset with every lane holding +1.
    localparam logic [LANE_W-1:0] LANE_ONE = LANE_W'(1);
    localparam logic [VW-1:0]     KRESET   = {LANES{LANE_ONE}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Architectural storage.
    logic [VW-1:0]     r_gen   [NGEN];
    logic [VW-1:0]     r_kbank [NBANKS][NKREG];

    // Kernel-load machinery.
    logic [LANE_W-1:0] r_shadow [NBEATS];
    logic [CW-1:0]     r_cnt;
    logic [KB-1:0]     r_tgt;
    state_t            r_state;
    state_t            w_next_state;

    // Registered status pulses.
    logic              r_wr_err;
    logic              r_kl_done;

    // Combinational control.
    logic              w_kl_ready;
    logic              w_kbusy;
    logic              w_commit;
    logic              w_beat_acc;
    logic              w_last_beat;
    logic              w_gen_wr;
    logic              w_kwin_wr;
    logic [VW-1:0]     w_rd1;
    logic [VW-1:0]     w_rd2;

    // Beat handshake and write classification.
    always_comb begin
        w_beat_acc  = kl_valid && w_kl_ready;
        w_last_beat = w_beat_acc && (r_cnt == CW'(NBEATS - 1));
        w_gen_wr    = we3 && (int'(ra3) < NGEN);
        // An all-zero mask is a no-op everywhere, so it never flags an error.
        w_kwin_wr   = we3 && (int'(ra3) >= NGEN) && (int'(ra3) < NREGS) && (|wmask);
    end

    // Load FSM: state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Load FSM: next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                // A one-beat bank would finish on its first beat.
                if (w_last_beat) begin
                    w_next_state = ST_COMMIT;
                end else if (w_beat_acc) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_last_beat) begin
                    w_next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Load FSM: outputs decoded from the current state.
    always_comb begin
        w_kl_ready = 1'b1;
        w_kbusy    = 1'b0;
        w_commit   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_kl_ready = 1'b1;
            end
            ST_LOAD: begin
                w_kl_ready = 1'b1;
                w_kbusy    = 1'b1;
            end
            ST_COMMIT: begin
                w_kl_ready = 1'b0;
                w_kbusy    = 1'b1;
                w_commit   = 1'b1;
            end
            default: begin
                w_kl_ready = 1'b0;
            end
        endcase
    end

    // Shadow buffer, beat counter and target bank; the bank is latched on the first beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            r_tgt <= '0;
            for (int s = 0; s < NBEATS; s++) begin
                r_shadow[s] <= '0;
            end
        end else if (w_beat_acc) begin
            r_shadow[SIW'(r_cnt)] <= kl_data;
            r_cnt                 <= w_last_beat ? '0 : r_cnt + CW'(1);
            if (r_state == ST_IDLE) begin
                r_tgt <= kl_bank;
            end
        end
    end

    // Live kernel banks change only in the COMMIT cycle, all lanes at once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < NBANKS; b++) begin
                for (int k = 0; k < NKREG; k++) begin
                    r_kbank[b][k] <= KRESET;
                end
            end
        end else if (w_commit) begin
            for (int k = 0; k < NKREG; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    r_kbank[r_tgt][k][l*LANE_W +: LANE_W] <= r_shadow[k*LANES + l];
                end
            end
        end
    end

    // General registers: masked lane writes. The kernel window is never written here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int g = 0; g < NGEN; g++) begin
                r_gen[g] <= '0;
            end
        end else if (w_gen_wr) begin
            for (int l = 0; l < LANES; l++) begin
                if (wmask[l]) begin
                    r_gen[GIW'(ra3)][l*LANE_W +: LANE_W] <= wd3[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Status pulses: wr_err follows a rejected kernel-window write; kl_done follows COMMIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_err  <= 1'b0;
            r_kl_done <= 1'b0;
        end else begin
            r_wr_err  <= w_kwin_wr;
            r_kl_done <= w_commit;
        end
    end

    // One read port: general register, or the selected bank inside the kernel window.
    function automatic logic [VW-1:0] f_read(input logic [AW-1:0] addr);
        logic [VW-1:0]  v;
        logic [KIW-1:0] kidx;
        v    = '0;
        kidx = KIW'(int'(addr) - NGEN);
        if (int'(addr) < NGEN) begin
            v = r_gen[GIW'(addr)];
        end else if (int'(addr) < NREGS) begin
            v = r_kbank[kernel][kidx];
        end
`ifdef RF_WRITE_BYPASS_EN
        // Write-through: only lanes being written this cycle are forwarded.
        if (w_gen_wr && (addr == ra3)) begin
            for (int l = 0; l < LANES; l++) begin
                if (wmask[l]) begin
                    v[l*LANE_W +: LANE_W] = wd3[l*LANE_W +: LANE_W];
                end
            end
        end
`endif
        return v;
    endfunction

    // Combinational read ports.
    always_comb begin
        w_rd1 = f_read(ra1);
        w_rd2 = f_read(ra2);
    end

    assign rd1         = w_rd1;
    assign rd2         = w_rd2;
    assign wr_err      = r_wr_err;
    assign kl_ready    = w_kl_ready;
    assign kl_done     = r_kl_done;
    assign kbusy       = w_kbusy;
    assign o_dbg_state = r_state;

endmodule
